// File: rtl/apb_pkg.sv
// Shared types and default widths for the APB master bridge and its helpers.
package apb_pkg;

    localparam int APB_ADDR_W = 32;
    localparam int APB_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_t;

endpackage

// File: rtl/apb_wait_timer.sv
// Counts ACCESS cycles spent waiting on pready and flags the cycle that
// uses up the last allowed wait, so the bridge can abort on that edge.
module apb_wait_timer #(
    parameter int TIMEOUT = 16
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    generate
        if (TIMEOUT == 0) begin : g_off
            logic unusedInputs;

            assign unusedInputs = ^{clk_i, rst_ni, clear_i, enable_i};
            assign expired_o    = 1'b0;
        end else begin : g_on
            localparam int CW = $clog2(TIMEOUT + 1);

            logic [CW-1:0] count_q;
            logic [CW-1:0] count_d;

            // Clear when a new transfer starts, otherwise count waiting cycles up to the limit
            always_comb begin
                count_d = count_q;
                if (clear_i) begin
                    count_d = '0;
                end else if (enable_i && (count_q != CW'(TIMEOUT))) begin
                    count_d = count_q + CW'(1);
                end
            end

            // Counter register, dropped to zero by reset at any time
            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    count_q <= '0;
                end else begin
                    count_q <= count_d;
                end
            end

            // The current waiting cycle is the last one allowed when TIMEOUT-1 waits already happened
            assign expired_o = enable_i && (count_q == CW'(TIMEOUT - 1));
        end
    endgenerate

endmodule

// File: rtl/apb_master_bridge.sv
// Converts a valid/ready command stream into APB3 transfers and returns one
// held response beat per completed or timed-out transfer.
module apb_master_bridge
    import apb_pkg::*;
#(
    parameter int ADDR_W  = APB_ADDR_W,
    parameter int DATA_W  = APB_DATA_W,
    parameter int TIMEOUT = 16
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              cmd_valid_i,
    output logic              cmd_ready_o,
    input  logic              cmd_write_i,
    input  logic [ADDR_W-1:0] cmd_addr_i,
    input  logic [DATA_W-1:0] cmd_wdata_i,
    output logic              rsp_valid_o,
    input  logic              rsp_ready_i,
    output logic [DATA_W-1:0] rsp_rdata_o,
    output logic              rsp_error_o,
    output logic              rsp_timeout_o,
    output logic              pselx_o,
    output logic              penable_o,
    output logic              pwrite_o,
    output logic [ADDR_W-1:0] paddr_o,
    output logic [DATA_W-1:0] pwdata_o,
    input  logic [DATA_W-1:0] prdata_i,
    input  logic              pready_i,
    input  logic              pslverror_i
);

    apb_state_t        state_q;
    apb_state_t        state_d;

    logic              cmdReady;
    logic              cmdAccept;
    logic              rspLoad;
    logic              timerClear;
    logic              timerEnable;
    logic              timerExpired;

    logic              pselx_q;
    logic              penable_q;
    logic              pwrite_q;
    logic              pwrite_d;
    logic [ADDR_W-1:0] paddr_q;
    logic [ADDR_W-1:0] paddr_d;
    logic [DATA_W-1:0] pwdata_q;
    logic [DATA_W-1:0] pwdata_d;

    logic              rspValid_q;
    logic              rspValid_d;
    logic [DATA_W-1:0] rspRdata_q;
    logic [DATA_W-1:0] rspRdata_d;
    logic              rspError_q;
    logic              rspError_d;
    logic              rspTimeout_q;
    logic              rspTimeout_d;

    apb_wait_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_wait_timer (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .clear_i   (timerClear),
        .enable_i  (timerEnable),
        .expired_o (timerExpired)
    );

    // State register; reset aborts any transfer in flight
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: accept into SETUP, always advance to ACCESS, leave ACCESS on ready or timeout
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (cmdAccept) begin
                    state_d = SETUP;
                end
            end
            SETUP: begin
                state_d = ACCESS;
            end
            ACCESS: begin
                if (rspLoad) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Per-state control: command handshake, timer control and response capture strobe
    always_comb begin
        cmdReady    = 1'b0;
        cmdAccept   = 1'b0;
        timerClear  = 1'b0;
        timerEnable = 1'b0;
        rspLoad     = 1'b0;
        case (state_q)
            IDLE: begin
                cmdReady   = rst_ni && (!rspValid_q || rsp_ready_i);
                cmdAccept  = cmdReady && cmd_valid_i;
                timerClear = cmdAccept;
            end
            ACCESS: begin
                timerEnable = !pready_i;
                rspLoad     = pready_i || timerExpired;
            end
            default: begin
            end
        endcase
    end

    // Address, direction and write data are loaded only on accept and held otherwise
    always_comb begin
        pwrite_d = pwrite_q;
        paddr_d  = paddr_q;
        pwdata_d = pwdata_q;
        if (cmdAccept) begin
            pwrite_d = cmd_write_i;
            paddr_d  = cmd_addr_i;
            pwdata_d = cmd_wdata_i;
        end
    end

    // Response slot: load on completion or abort, otherwise drain when the consumer takes it
    always_comb begin
        rspValid_d   = rspValid_q;
        rspRdata_d   = rspRdata_q;
        rspError_d   = rspError_q;
        rspTimeout_d = rspTimeout_q;
        if (rspLoad) begin
            rspValid_d = 1'b1;
            if (pready_i) begin
                rspRdata_d   = pwrite_q ? '0 : prdata_i;
                rspError_d   = pslverror_i;
                rspTimeout_d = 1'b0;
            end else begin
                rspRdata_d   = '0;
                rspError_d   = 1'b1;
                rspTimeout_d = 1'b1;
            end
        end else if (rsp_ready_i) begin
            rspValid_d = 1'b0;
        end
    end

    // Registered APB and response outputs; APB select/enable follow the state being entered
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pselx_q      <= 1'b0;
            penable_q    <= 1'b0;
            pwrite_q     <= 1'b0;
            paddr_q      <= '0;
            pwdata_q     <= '0;
            rspValid_q   <= 1'b0;
            rspRdata_q   <= '0;
            rspError_q   <= 1'b0;
            rspTimeout_q <= 1'b0;
        end else begin
            pselx_q      <= (state_d != IDLE);
            penable_q    <= (state_d == ACCESS);
            pwrite_q     <= pwrite_d;
            paddr_q      <= paddr_d;
            pwdata_q     <= pwdata_d;
            rspValid_q   <= rspValid_d;
            rspRdata_q   <= rspRdata_d;
            rspError_q   <= rspError_d;
            rspTimeout_q <= rspTimeout_d;
        end
    end

    assign cmd_ready_o   = cmdReady;
    assign pselx_o       = pselx_q;
    assign penable_o     = penable_q;
    assign pwrite_o      = pwrite_q;
    assign paddr_o       = paddr_q;
    assign pwdata_o      = pwdata_q;
    assign rsp_valid_o   = rspValid_q;
    assign rsp_rdata_o   = rspRdata_q;
    assign rsp_error_o   = rspError_q;
    assign rsp_timeout_o = rspTimeout_q;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Self-checking bench for apb_master_bridge: directed scenarios plus random
// transfers against a transfer-level reference model of the bridge.
module tb_apb_master_bridge;

    localparam int ADDR_W    = 32;
    localparam int DATA_W    = 32;
    localparam int TIMEOUT_P = 16;

    logic              clk = 1'b0;
    logic              rstN;
    logic              cmdValid;
    logic              cmdReady;
    logic              cmdWrite;
    logic [ADDR_W-1:0] cmdAddr;
    logic [DATA_W-1:0] cmdWdata;
    logic              rspValid;
    logic              rspReady;
    logic [DATA_W-1:0] rspRdata;
    logic              rspError;
    logic              rspTimeout;
    logic              pselx;
    logic              penable;
    logic              pwrite;
    logic [ADDR_W-1:0] paddr;
    logic [DATA_W-1:0] pwdata;
    logic [DATA_W-1:0] prdata;
    logic              pready;
    logic              pslverror;

    int checkCount = 0;
    int failCount  = 0;

    bit                rspPending = 1'b0;
    logic [DATA_W-1:0] lastRdata;
    logic              lastError;
    logic              lastTimeout;

    apb_master_bridge #(
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .TIMEOUT (TIMEOUT_P)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rstN),
        .cmd_valid_i   (cmdValid),
        .cmd_ready_o   (cmdReady),
        .cmd_write_i   (cmdWrite),
        .cmd_addr_i    (cmdAddr),
        .cmd_wdata_i   (cmdWdata),
        .rsp_valid_o   (rspValid),
        .rsp_ready_i   (rspReady),
        .rsp_rdata_o   (rspRdata),
        .rsp_error_o   (rspError),
        .rsp_timeout_o (rspTimeout),
        .pselx_o       (pselx),
        .penable_o     (penable),
        .pwrite_o      (pwrite),
        .paddr_o       (paddr),
        .pwdata_o      (pwdata),
        .prdata_i      (prdata),
        .pready_i      (pready),
        .pslverror_i   (pslverror)
    );

    // Free-running clock, rising edges at 5, 15, 25 ...
    always #5 clk = ~clk;

    // Hard stop in case the flow itself wedges
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    // Random junk on the slave inputs; the bridge must ignore it outside a ready ACCESS cycle
    task automatic scrambleSlave();
        pready    = 1'($urandom_range(0, 1));
        pslverror = 1'($urandom_range(0, 1));
        prdata    = $urandom;
    endtask

    // One complete transfer, entered and left at a falling edge. The slave holds pready low
    // for `waits` ACCESS cycles, then answers with slvData/slvErr. A response still held from
    // the previous transfer is back-pressured for holdCycles cycles before being released in
    // the same cycle that this command is accepted.
    task automatic applyStimulus(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                                 input int waits, input logic [31:0] slvData, input logic slvErr,
                                 input int holdCycles);
        bit          expTimeout;
        int          expAccess;
        logic [31:0] expData;
        logic        expError;
        int          accessCycles;
        bit          done;

        expTimeout = (TIMEOUT_P > 0) && (waits >= TIMEOUT_P);
        expAccess  = expTimeout ? TIMEOUT_P : waits + 1;
        expData    = (expTimeout || wr) ? 32'h0 : slvData;
        expError   = expTimeout ? 1'b1 : slvErr;

        cmdValid = 1'b1;
        cmdWrite = wr;
        cmdAddr  = addr;
        cmdWdata = wdata;
        scrambleSlave();

        if (rspPending) begin
            for (int h = 0; h < holdCycles; h++) begin
                #1;
                checkOutput("bp_cmd_ready", 32'(cmdReady), 0);
                checkOutput("bp_pselx", 32'(pselx), 0);
                checkOutput("bp_rsp_valid", 32'(rspValid), 1);
                checkOutput("bp_rsp_rdata", rspRdata, lastRdata);
                checkOutput("bp_rsp_error", 32'(rspError), 32'(lastError));
                checkOutput("bp_rsp_timeout", 32'(rspTimeout), 32'(lastTimeout));
                @(negedge clk);
                scrambleSlave();
            end
            rspReady = 1'b1;
        end
        #1;
        checkOutput("accept_cmd_ready", 32'(cmdReady), 1);
        @(negedge clk);

        rspReady   = 1'b0;
        rspPending = 1'b0;
        cmdValid   = 1'b0;
        cmdWrite   = 1'($urandom_range(0, 1));
        cmdAddr    = $urandom;
        cmdWdata   = $urandom;
        checkOutput("setup_pselx", 32'(pselx), 1);
        checkOutput("setup_penable", 32'(penable), 0);
        checkOutput("setup_rsp_valid", 32'(rspValid), 0);
        checkOutput("setup_cmd_ready", 32'(cmdReady), 0);
        checkOutput("setup_paddr", paddr, addr);
        checkOutput("setup_pwrite", 32'(pwrite), 32'(wr));
        checkOutput("setup_pwdata", pwdata, wdata);
        scrambleSlave();
        @(negedge clk);

        accessCycles = 0;
        done         = 1'b0;
        for (int k = 0; k < TIMEOUT_P + 4 && !done; k++) begin
            if (pselx && penable) begin
                accessCycles++;
                checkOutput("access_paddr", paddr, addr);
                checkOutput("access_pwdata", pwdata, wdata);
                checkOutput("access_rsp_valid", 32'(rspValid), 0);
                if (k == waits) begin
                    pready    = 1'b1;
                    prdata    = slvData;
                    pslverror = slvErr;
                end else begin
                    pready    = 1'b0;
                    prdata    = $urandom;
                    pslverror = 1'($urandom_range(0, 1));
                end
                @(negedge clk);
            end else begin
                done = 1'b1;
            end
        end

        checkOutput("access_cycles", 32'(accessCycles), 32'(expAccess));
        checkOutput("done_pselx", 32'(pselx), 0);
        checkOutput("done_penable", 32'(penable), 0);
        checkOutput("done_paddr_held", paddr, addr);
        checkOutput("rsp_valid", 32'(rspValid), 1);
        checkOutput("rsp_rdata", rspRdata, expData);
        checkOutput("rsp_error", 32'(rspError), 32'(expError));
        checkOutput("rsp_timeout", 32'(rspTimeout), 32'(expTimeout));
        scrambleSlave();

        lastRdata   = expData;
        lastError   = expError;
        lastTimeout = expTimeout;
        rspPending  = 1'b1;
    endtask

    // Consume a held response with no command waiting
    task automatic drainResponse();
        if (rspPending) begin
            rspReady = 1'b1;
            @(negedge clk);
            rspReady   = 1'b0;
            rspPending = 1'b0;
            checkOutput("drain_rsp_valid", 32'(rspValid), 0);
            checkOutput("drain_pselx", 32'(pselx), 0);
        end
    endtask

    // Read of 1225 interrupted by reset while the slave is still stalling in ACCESS
    task automatic applyResetMidTransfer();
        drainResponse();
        cmdValid = 1'b1;
        cmdWrite = 1'b0;
        cmdAddr  = 32'd1225;
        cmdWdata = 32'hA5A5_0F0F;
        pready   = 1'b0;
        #1;
        checkOutput("rst_accept_ready", 32'(cmdReady), 1);
        @(negedge clk);
        cmdValid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checkOutput("rst_in_access", 32'(penable), 1);
        #2;
        rstN = 1'b0;
        #1;
        checkOutput("rst_async_pselx", 32'(pselx), 0);
        checkOutput("rst_async_penable", 32'(penable), 0);
        checkOutput("rst_async_paddr", paddr, 0);
        checkOutput("rst_async_pwdata", pwdata, 0);
        checkOutput("rst_async_pwrite", 32'(pwrite), 0);
        checkOutput("rst_async_rsp_valid", 32'(rspValid), 0);
        checkOutput("rst_async_rsp_rdata", rspRdata, 0);
        checkOutput("rst_async_rsp_error", 32'(rspError), 0);
        checkOutput("rst_async_rsp_timeout", 32'(rspTimeout), 0);
        checkOutput("rst_async_cmd_ready", 32'(cmdReady), 0);
        pready = 1'b1;
        prdata = 32'hFFFF_FFFF;
        @(negedge clk);
        checkOutput("rst_held_rsp_valid", 32'(rspValid), 0);
        checkOutput("rst_held_cmd_ready", 32'(cmdReady), 0);
        rstN   = 1'b1;
        pready = 1'b0;
        #1;
        checkOutput("rst_release_cmd_ready", 32'(cmdReady), 1);
        @(negedge clk);
        checkOutput("rst_release_rsp_valid", 32'(rspValid), 0);
        checkOutput("rst_release_pselx", 32'(pselx), 0);
    endtask

    // Main sequence: reset, directed cases, then randomized transfers
    initial begin
        rstN      = 1'b0;
        cmdValid  = 1'b0;
        cmdWrite  = 1'b0;
        cmdAddr   = '0;
        cmdWdata  = '0;
        rspReady  = 1'b0;
        pready    = 1'b0;
        prdata    = '0;
        pslverror = 1'b0;
        lastRdata   = '0;
        lastError   = 1'b0;
        lastTimeout = 1'b0;

        #1;
        checkOutput("reset_pselx", 32'(pselx), 0);
        checkOutput("reset_penable", 32'(penable), 0);
        checkOutput("reset_paddr", paddr, 0);
        checkOutput("reset_rsp_valid", 32'(rspValid), 0);
        checkOutput("reset_cmd_ready", 32'(cmdReady), 0);
        @(negedge clk);
        @(negedge clk);
        rstN = 1'b1;
        #1;
        checkOutput("post_reset_cmd_ready", 32'(cmdReady), 1);
        @(negedge clk);

        applyStimulus(1'b1, 32'd1215, 32'hDEADBEEF, 0, 32'h0BAD_F00D, 1'b0, 0);
        applyStimulus(1'b0, 32'd1221, 32'h1111_2222, 2, 32'h12345678, 1'b0, 2);
        applyStimulus(1'b1, 32'd2047, 32'h0000_7777, 1, 32'h5555_AAAA, 1'b1, 1);
        applyStimulus(1'b0, 32'd2048, 32'h0, 0, 32'hCAFE_0001, 1'b0, 3);
        applyStimulus(1'b0, 32'd3000, 32'h0, TIMEOUT_P, 32'h9999_9999, 1'b0, 0);
        applyStimulus(1'b0, 32'd3001, 32'h0, TIMEOUT_P - 1, 32'h7654_3210, 1'b0, 2);

        applyResetMidTransfer();
        rspPending = 1'b0;
        applyStimulus(1'b0, 32'd1226, 32'h0, 1, 32'hFEED_1226, 1'b0, 0);

        for (int t = 0; t < 40; t++) begin
            logic        wr;
            logic [31:0] addr;
            logic [31:0] wdata;
            int          waits;
            logic [31:0] slvData;
            logic        slvErr;
            int          hold;
            wr      = 1'($urandom_range(0, 1));
            addr    = $urandom;
            wdata   = $urandom;
            waits   = ($urandom_range(0, 7) == 0) ? int'($urandom_range(14, 18)) : int'($urandom_range(0, 4));
            slvData = $urandom;
            slvErr  = ($urandom_range(0, 3) == 0);
            hold    = int'($urandom_range(0, 3));
            applyStimulus(wr, addr, wdata, waits, slvData, slvErr, hold);
        end
        drainResponse();

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule
